quad_enc_multi: RTL and testbench

Parametrised multi-channel quadrature encoder front end: per channel it synchronises A/B/Z, decodes ×4 steps, keeps a signed position counter with a programmable clamp or wrap range, and measures A-rising-edge period for speed. It sits between the encoder input pins and the scaling/DAC pipelines, replacing per-channel hand-built counters. New over single-channel logic: N channels, signed output, range-0 free-run, illegal-transition detection, stall/timeout flag, and optional input deglitching.

---
 rtl/quad_enc_multi_if.sv | 22 ++
 rtl/quad_enc_multi.sv | 119 +++++++++++
 tb/tb_quad_enc_multi.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_enc_multi_if.sv
// quad_enc_multi_if: encoder pins, per-channel controls and position/speed results
// master: drives raw enc_a/enc_b/enc_z/ext_pls pins and z_en/z_fall/wrap/range/err_clr controls
// slave : the decoder, returning pos/dir/period/period_vld/stall/err
interface quad_enc_multi_if #(
  parameter int CH = 2,
  parameter int CNT_W = 16,
  parameter int PER_W = 32
);
  logic [CH-1:0] enc_a, enc_b, enc_z, z_en, z_fall, wrap;
  logic ext_pls, err_clr;
  logic [CH*CNT_W-1:0] range, pos;
  logic [CH-1:0] dir, period_vld, stall, err;
  logic [CH*PER_W-1:0] period;
  modport master (
    output enc_a, enc_b, enc_z, ext_pls, z_en, z_fall, wrap, range, err_clr,
    input pos, dir, period, period_vld, stall, err
  );
  modport slave (
    input enc_a, enc_b, enc_z, ext_pls, z_en, z_fall, wrap, range, err_clr,
    output pos, dir, period, period_vld, stall, err
  );
endinterface

// File: rtl/quad_enc_multi.sv
// quad_enc_multi: multi-channel x4 quadrature decoder with signed clamp/wrap position, A-period speed, stall and illegal-step flags
// Ports: CLK_60 60 MHz clock; RST asynchronous active-high reset; bus (slave) with raw
//   enc_a/enc_b/enc_z per channel and shared ext_pls (asynchronous), z_en/z_fall/wrap/range
//   per channel, shared err_clr, and pos/dir/period/period_vld/stall/err results.
// Build option: QENC_GLITCH_FILTER_EN accepts each synchronised input only after FILT_LEN equal samples.
module quad_enc_multi #(
  parameter int CH = 2,
  parameter int CNT_W = 16,
  parameter int PER_W = 32,
  parameter int PER_MAX = 2500000,
  parameter int FILT_LEN = 4
) (
  input logic CLK_60,
  input logic RST,
  quad_enc_multi_if.slave bus
);
  localparam int SW = 3 * CH + 1;
  localparam logic [PER_W-1:0] PM = PER_W'(PER_MAX);
  // sampled vector layout: {ext_pls, z[CH], b[CH], a[CH]}
  logic [SW-1:0] s1, s2, cur, prv;
  logic ext_rise;
  if (FILT_LEN < 1 || PER_MAX < 1) begin : g_bad_cfg
    $error("FILT_LEN and PER_MAX must be at least 1");
  end
  always_ff @(posedge CLK_60 or posedge RST)
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
      prv <= '0;
    end else begin
      s1 <= {bus.ext_pls, bus.enc_z, bus.enc_b, bus.enc_a};
      s2 <= s1;
      prv <= cur;
    end
`ifdef QENC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  for (genvar i = 0; i < SW; i++) begin : g_filt
    logic f;
    logic [FW-1:0] n;
    always_ff @(posedge CLK_60 or posedge RST)
      if (RST) begin
        f <= 1'b0;
        n <= '0;
      end else if (s2[i] == f) n <= '0;
      else if (n == FW'(FILT_LEN - 1)) begin
        f <= s2[i];
        n <= '0;
      end else n <= n + FW'(1);
    assign cur[i] = f;
  end
`else
  assign cur = s2;
`endif
  assign ext_rise = cur[3*CH] & ~prv[3*CH];
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [1:0] ip, ic, dlt;
    logic up, dn, ill, zero, a_rise, d, e, st, vld;
    logic signed [CNT_W-1:0] r, lo, hi, p, p_nx;
    logic [PER_W-1:0] cnt, per;
    // Gray position 00,10,11,01 -> 0..3; the index difference gives the step direction
    assign ip = {prv[CH+c], prv[CH+c] ^ prv[c]};
    assign ic = {cur[CH+c], cur[CH+c] ^ cur[c]};
    assign dlt = ic - ip;
    assign up = dlt == 2'd1;
    assign dn = dlt == 2'd3;
    assign ill = dlt == 2'd2;
    // z_fall selects the active Z edge: the new level must differ from z_fall
    assign zero = ext_rise | (bus.z_en[c] & (cur[2*CH+c] ^ prv[2*CH+c]) & (cur[2*CH+c] ^ bus.z_fall[c]));
    assign a_rise = cur[c] & ~prv[c];
    assign r = bus.range[c*CNT_W +: CNT_W];
    assign lo = -r;
    assign hi = r - CNT_W'(1);
    always_comb
      if (zero) p_nx = '0;
      else if (r == '0) p_nx = up ? p + CNT_W'(1) : dn ? p - CNT_W'(1) : p;
      else if (p < lo) p_nx = lo;
      else if (p > hi) p_nx = hi;
      else if (up) p_nx = (p == hi) ? (bus.wrap[c] ? lo : hi) : p + CNT_W'(1);
      else if (dn) p_nx = (p == lo) ? (bus.wrap[c] ? hi : lo) : p - CNT_W'(1);
      else p_nx = p;
    always_ff @(posedge CLK_60 or posedge RST)
      if (RST) begin
        p <= '0;
        d <= 1'b0;
        e <= 1'b0;
      end else begin
        p <= p_nx;
        if (up | dn) d <= dn;
        e <= ill | (e & ~bus.err_clr);
      end
    // a rising edge while stalled only restarts timing; that partial interval is discarded
    always_ff @(posedge CLK_60 or posedge RST)
      if (RST) begin
        cnt <= '0;
        per <= '1;
        vld <= 1'b0;
        st <= 1'b1;
      end else begin
        vld <= a_rise & ~st;
        if (a_rise) begin
          cnt <= '0;
          st <= 1'b0;
          if (!st) per <= cnt + PER_W'(1);
        end else if (cnt != PM) begin
          cnt <= cnt + PER_W'(1);
          if (cnt == PM - PER_W'(1)) begin
            st <= 1'b1;
            per <= '1;
          end
        end
      end
    assign bus.pos[c*CNT_W +: CNT_W] = p;
    assign bus.dir[c] = d;
    assign bus.err[c] = e;
    assign bus.period[c*PER_W +: PER_W] = per;
    assign bus.period_vld[c] = vld;
    assign bus.stall[c] = st;
  end
endmodule

// File: tb/tb_quad_enc_multi.sv
// tb_quad_enc_multi: randomized bench for quad_enc_multi against an integer position/period model
module tb_quad_enc_multi;
  localparam int CH = 2;
  localparam int CNT_W = 10;
  localparam int PER_W = 32;
  localparam int PER_MAX = 500;
  localparam int FR_STEPS = 1100;
  localparam logic [PER_W-1:0] PER1 = '1;
  localparam logic [CH*PER_W-1:0] PER_ALL1 = '1;
  logic CLK_60 = 1'b0;
  logic RST = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int ph [CH];
  int mp [CH];
  int rr [CH];
  bit ww [CH];
  int vld_cnt = 0;
  logic [PER_W-1:0] vld_per = '0;

  quad_enc_multi_if #(.CH(CH), .CNT_W(CNT_W), .PER_W(PER_W)) bus ();
  quad_enc_multi #(.CH(CH), .CNT_W(CNT_W), .PER_W(PER_W), .PER_MAX(PER_MAX), .FILT_LEN(4)) dut (
    .CLK_60(CLK_60), .RST(RST), .bus(bus.slave)
  );

  always #8 CLK_60 = ~CLK_60;

  always @(negedge CLK_60)
    if (bus.period_vld[0]) begin
      vld_cnt++;
      vld_per = bus.period[PER_W-1:0];
    end

  function automatic int wrap_w(int v);
    int m = v & ((1 << CNT_W) - 1);
    return (m >= (1 << (CNT_W - 1))) ? m - (1 << CNT_W) : m;
  endfunction

  function automatic int mclamp(int p, int r);
    if (r == 0) return p;
    if (p < -r) return -r;
    if (p > r - 1) return r - 1;
    return p;
  endfunction

  function automatic int mstep(int p, int d, int r, bit w);
    int n = p + d;
    if (r == 0) return wrap_w(n);
    if (n > r - 1) return w ? -r : r - 1;
    if (n < -r) return w ? r - 1 : -r;
    return n;
  endfunction

  function automatic int rd_pos(int c);
    logic [CNT_W-1:0] v = bus.pos[c*CNT_W +: CNT_W];
    return int'($signed(v));
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge CLK_60);
  endtask

  task automatic drive(int c);
    bus.enc_a[c] = (ph[c] == 1 || ph[c] == 2);
    bus.enc_b[c] = (ph[c] >= 2);
  endtask

  task automatic step(int c, int d, int gap);
    ph[c] = (ph[c] + d) & 3;
    drive(c);
    mp[c] = mstep(mp[c], d, rr[c], ww[c]);
    tick(gap);
  endtask

  task automatic set_cfg(int c, int r, bit w);
    rr[c] = r;
    ww[c] = w;
    bus.range[c*CNT_W +: CNT_W] = r[CNT_W-1:0];
    bus.wrap[c] = w;
    mp[c] = mclamp(mp[c], r);
    tick(3);
  endtask

  task automatic pulse_ext();
    bus.ext_pls = 1'b1;
    tick(4);
    for (int k = 0; k < CH; k++) mp[k] = 0;
    bus.ext_pls = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(2);
    vectors++; if (bus.pos !== '0) begin miscompares++; $display("FAIL reset_pos got %h exp 0", bus.pos); end
    vectors++; if (bus.dir !== '0) begin miscompares++; $display("FAIL reset_dir got %b exp 0", bus.dir); end
    vectors++; if (bus.period !== PER_ALL1) begin miscompares++; $display("FAIL reset_period got %h exp all ones", bus.period); end
    vectors++; if (bus.period_vld !== '0) begin miscompares++; $display("FAIL reset_vld got %b exp 0", bus.period_vld); end
    vectors++; if (bus.stall !== '1) begin miscompares++; $display("FAIL reset_stall got %b exp 11", bus.stall); end
    vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL reset_err got %b exp 0", bus.err); end
  endtask

  task automatic test_clamp();
    set_cfg(0, 4, 1'b0);
    set_cfg(1, 4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 4);
      vectors++; if (rd_pos(0) !== mp[0]) begin miscompares++; $display("FAIL clamp_step%0d got %0d exp %0d", i, rd_pos(0), mp[0]); end
    end
    vectors++; if (rd_pos(0) !== 3) begin miscompares++; $display("FAIL clamp_hold got %0d exp 3", rd_pos(0)); end
    vectors++; if (rd_pos(1) !== 0) begin miscompares++; $display("FAIL clamp_ch1 got %0d exp 0", rd_pos(1)); end
    vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL clamp_err got %b exp 0", bus.err); end
    vectors++; if (bus.dir[0] !== 1'b0) begin miscompares++; $display("FAIL clamp_dir got %b exp 0", bus.dir[0]); end
  endtask

  task automatic test_wrap();
    set_cfg(0, 4, 1'b1);
    step(0, 1, 4);
    vectors++; if (rd_pos(0) !== -4) begin miscompares++; $display("FAIL wrap_hi got %0d exp -4", rd_pos(0)); end
    vectors++; if (bus.dir[0] !== 1'b0) begin miscompares++; $display("FAIL wrap_dir_up got %b exp 0", bus.dir[0]); end
    step(0, -1, 4);
    vectors++; if (rd_pos(0) !== 3) begin miscompares++; $display("FAIL wrap_lo got %0d exp 3", rd_pos(0)); end
    vectors++; if (bus.dir[0] !== 1'b1) begin miscompares++; $display("FAIL wrap_dir_dn got %b exp 1", bus.dir[0]); end
    set_cfg(0, 2, 1'b1);
    vectors++; if (rd_pos(0) !== 1) begin miscompares++; $display("FAIL shrink got %0d exp 1", rd_pos(0)); end
    step(0, 1, 4);
    vectors++; if (rd_pos(0) !== -2) begin miscompares++; $display("FAIL shrink_wrap got %0d exp -2", rd_pos(0)); end
  endtask

  task automatic test_free_run();
    set_cfg(1, 0, 1'b0);
    pulse_ext();
    vectors++; if (bus.pos !== '0) begin miscompares++; $display("FAIL ext_zero got %h exp 0", bus.pos); end
    for (int i = 0; i < FR_STEPS; i++) step(1, 1, 2);
    tick(3);
    vectors++; if (rd_pos(1) !== FR_STEPS - (1 << CNT_W)) begin miscompares++; $display("FAIL free_run got %0d exp %0d", rd_pos(1), FR_STEPS - (1 << CNT_W)); end
    vectors++; if (rd_pos(1) !== mp[1]) begin miscompares++; $display("FAIL free_run_model got %0d exp %0d", rd_pos(1), mp[1]); end
    vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL free_run_err got %b exp 0", bus.err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int c;
      int d;
      if (i % 40 == 0)
        for (int k = 0; k < CH; k++) begin
          set_cfg(k, $urandom_range(0, 8), 1'($urandom_range(0, 1)));
          vectors++; if (rd_pos(k) !== mp[k]) begin miscompares++; $display("FAIL rnd_cfg ch%0d got %0d exp %0d", k, rd_pos(k), mp[k]); end
        end
      c = $urandom_range(0, CH - 1);
      d = $urandom_range(0, 1) ? 1 : -1;
      step(c, d, 4);
      for (int k = 0; k < CH; k++) begin
        vectors++; if (rd_pos(k) !== mp[k]) begin miscompares++; $display("FAIL rnd_pos%0d ch%0d got %0d exp %0d", i, k, rd_pos(k), mp[k]); end
      end
      vectors++; if (bus.dir[c] !== (d < 0)) begin miscompares++; $display("FAIL rnd_dir%0d ch%0d got %b exp %b", i, c, bus.dir[c], d < 0); end
    end
  endtask

  task automatic test_illegal();
    int p0 = mp[0];
    ph[0] = (ph[0] + 2) & 3;
    drive(0);
    tick(4);
    vectors++; if (rd_pos(0) !== p0) begin miscompares++; $display("FAIL ill_pos got %0d exp %0d", rd_pos(0), p0); end
    vectors++; if (bus.err !== 2'b01) begin miscompares++; $display("FAIL ill_err got %b exp 01", bus.err); end
    step(0, 1, 4);
    vectors++; if (bus.err[0] !== 1'b1) begin miscompares++; $display("FAIL ill_sticky got %b exp 1", bus.err[0]); end
    vectors++; if (rd_pos(0) !== mp[0]) begin miscompares++; $display("FAIL ill_resume got %0d exp %0d", rd_pos(0), mp[0]); end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(2);
    vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL ill_clr got %b exp 00", bus.err); end
    ph[0] = (ph[0] + 2) & 3;
    drive(0);
    tick(2);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(2);
    vectors++; if (bus.err[0] !== 1'b1) begin miscompares++; $display("FAIL ill_vs_clr got %b exp 1", bus.err[0]); end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(2);
    vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL ill_clr2 got %b exp 00", bus.err); end
  endtask

  task automatic test_zero();
    set_cfg(0, 8, 1'b0);
    set_cfg(1, 8, 1'b0);
    bus.z_en = CH'(1);
    bus.z_fall = '0;
    pulse_ext();
    step(0, 1, 4);
    step(0, 1, 4);
    step(1, 1, 4);
    bus.enc_z[0] = 1'b1;
    step(0, 1, 4);
    mp[0] = 0;
    vectors++; if (rd_pos(0) !== 0) begin miscompares++; $display("FAIL z_rise_step got %0d exp 0", rd_pos(0)); end
    vectors++; if (rd_pos(1) !== 1) begin miscompares++; $display("FAIL z_ch1 got %0d exp 1", rd_pos(1)); end
    step(0, 1, 4);
    step(0, 1, 4);
    bus.enc_z[0] = 1'b0;
    tick(4);
    vectors++; if (rd_pos(0) !== 2) begin miscompares++; $display("FAIL z_fall_ign got %0d exp 2", rd_pos(0)); end
    bus.z_fall[0] = 1'b1;
    bus.enc_z[0] = 1'b1;
    tick(4);
    vectors++; if (rd_pos(0) !== 2) begin miscompares++; $display("FAIL z_rise_ign got %0d exp 2", rd_pos(0)); end
    bus.enc_z[0] = 1'b0;
    tick(4);
    mp[0] = 0;
    vectors++; if (rd_pos(0) !== 0) begin miscompares++; $display("FAIL z_fall_zero got %0d exp 0", rd_pos(0)); end
    bus.enc_z[1] = 1'b1;
    tick(4);
    bus.enc_z[1] = 1'b0;
    tick(4);
    vectors++; if (rd_pos(1) !== mp[1]) begin miscompares++; $display("FAIL z_en_off got %0d exp %0d", rd_pos(1), mp[1]); end
    bus.z_en = '0;
    bus.z_fall = '0;
  endtask

  task automatic test_period();
    int prev = 0;
    int base;
    while (ph[0] != 0) step(0, 1, 4);
    tick(PER_MAX + 20);
    vectors++; if (bus.stall[0] !== 1'b1) begin miscompares++; $display("FAIL per_stall got %b exp 1", bus.stall[0]); end
    vectors++; if (bus.period[PER_W-1:0] !== PER1) begin miscompares++; $display("FAIL per_stall_val got %h exp %h", bus.period[PER_W-1:0], PER1); end
    for (int k = 0; k < 7; k++) begin
      int g [4];
      for (int j = 0; j < 4; j++) g[j] = (k == 4) ? 125 : (k == 5) ? (j == 3 ? 126 : 125) : $urandom_range(6, 100);
      base = vld_cnt;
      step(0, 1, g[0]);
      if (k == 0 || k == 6) begin
        vectors++; if (vld_cnt !== base) begin miscompares++; $display("FAIL per_discard%0d got %0d pulses exp 0", k, vld_cnt - base); end
        vectors++; if (bus.period[PER_W-1:0] !== PER1) begin miscompares++; $display("FAIL per_kept%0d got %h exp %h", k, bus.period[PER_W-1:0], PER1); end
      end else begin
        vectors++; if (vld_cnt !== base + 1) begin miscompares++; $display("FAIL per_vld%0d got %0d pulses exp 1", k, vld_cnt - base); end
        vectors++; if (vld_per !== PER_W'(prev)) begin miscompares++; $display("FAIL per_val%0d got %0d exp %0d", k, vld_per, prev); end
        vectors++; if (bus.period[PER_W-1:0] !== PER_W'(prev)) begin miscompares++; $display("FAIL per_hold%0d got %0d exp %0d", k, bus.period[PER_W-1:0], prev); end
        vectors++; if (bus.period_vld[0] !== 1'b0) begin miscompares++; $display("FAIL per_pulse%0d got %b exp 0", k, bus.period_vld[0]); end
      end
      vectors++; if (bus.stall[0] !== 1'b0) begin miscompares++; $display("FAIL per_unstall%0d got %b exp 0", k, bus.stall[0]); end
      for (int j = 1; j < 4; j++) step(0, 1, g[j]);
      prev = g[0] + g[1] + g[2] + g[3];
    end
  endtask

  task automatic test_reset_mid();
    int base;
    for (int c = 0; c < CH; c++) while (ph[c] != 0) step(c, 1, 4);
    #2 RST = 1'b1;
    #1;
    vectors++; if (bus.pos !== '0) begin miscompares++; $display("FAIL mid_rst_pos got %h exp 0", bus.pos); end
    vectors++; if (bus.stall !== '1 || bus.period !== PER_ALL1) begin miscompares++; $display("FAIL mid_rst_per got stall %b period %h exp 11 / all ones", bus.stall, bus.period); end
    vectors++; if (bus.dir !== '0 || bus.err !== '0) begin miscompares++; $display("FAIL mid_rst_flags got dir %b err %b exp 0", bus.dir, bus.err); end
    tick(3);
    RST = 1'b0;
    for (int c = 0; c < CH; c++) mp[c] = 0;
    tick(2);
    base = vld_cnt;
    step(0, 1, 6);
    vectors++; if (vld_cnt !== base) begin miscompares++; $display("FAIL mid_rst_vld got %0d pulses exp 0", vld_cnt - base); end
    vectors++; if (bus.stall[0] !== 1'b0) begin miscompares++; $display("FAIL mid_rst_unstall got %b exp 0", bus.stall[0]); end
    vectors++; if (rd_pos(0) !== mp[0]) begin miscompares++; $display("FAIL mid_rst_step got %0d exp %0d", rd_pos(0), mp[0]); end
  endtask

  initial begin
    bus.enc_a = '0;
    bus.enc_b = '0;
    bus.enc_z = '0;
    bus.ext_pls = 1'b0;
    bus.z_en = '0;
    bus.z_fall = '0;
    bus.wrap = '0;
    bus.range = '0;
    bus.err_clr = 1'b0;
    for (int k = 0; k < CH; k++) begin
      ph[k] = 0;
      mp[k] = 0;
      rr[k] = 0;
      ww[k] = 1'b0;
    end
    test_reset();
    test_clamp();
    test_wrap();
    test_free_run();
    test_random();
    test_illegal();
    test_zero();
    test_period();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
